// File: rtl/roulette_param.sv
// Roulette game controller: a player balance is staked on one wheel spin at a
// time. Each accepted spin is evaluated in a single EVAL cycle, and the game
// ends in WON or LOST.
module roulette_param #(
  parameter int NUM_W     = 5,
  parameter int MAX_NUM   = 31,
  parameter int BAL_W     = 6,
  parameter int BET_W     = 3,
  parameter int START_BAL = 10,
  parameter int WIN_BAL   = 20,
  parameter int EXACT_PAY = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_game,
  input  logic             spin,
  input  logic [1:0]       mode,
  input  logic [NUM_W-1:0] guess,
  input  logic [BET_W-1:0] bet,
  input  logic [NUM_W-1:0] randnum,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       state_out,
  output logic             win_pulse,
  output logic             lose_pulse,
  output logic             bet_err,
  output logic [7:0]       rounds
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_WON  = 3'd3;
  localparam logic [2:0] S_LOST = 3'd4;

  localparam logic [1:0] M_EXACT = 2'b00;
  localparam logic [1:0] M_EVEN  = 2'b01;
  localparam logic [1:0] M_ODD   = 2'b10;

  // Wide enough that balance + bet*EXACT_PAY can never wrap before clamping.
  localparam int PAY_W = $clog2(EXACT_PAY + 1);
  localparam int EXT_W = BAL_W + BET_W + PAY_W + 4;

  localparam logic [EXT_W-1:0] BAL_MAX_X = EXT_W'((1 << BAL_W) - 1);
  localparam logic [EXT_W-1:0] WIN_X     = EXT_W'(WIN_BAL);
  localparam logic [EXT_W-1:0] PAY_X     = EXT_W'(EXACT_PAY);
  localparam logic [BAL_W-1:0] START_V   = BAL_W'(START_BAL);
  localparam logic [NUM_W-1:0] MAX_V     = NUM_W'(MAX_NUM);
  localparam logic [NUM_W-1:0] HALF_V    = NUM_W'(MAX_NUM / 2);

  logic [2:0]       state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [7:0]       rounds_q, rounds_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic             err_q, err_d;
  logic [1:0]       mode_q, mode_d;
  logic [NUM_W-1:0] guess_q, guess_d;
  logic [BET_W-1:0] bet_q, bet_d;
  logic [NUM_W-1:0] rand_q, rand_d;

  logic [NUM_W-1:0] eff_rand;
  logic             round_win;
  logic [EXT_W-1:0] bal_x, bet_x, gain_x, sum_x, new_bal_x;
  logic             spin_ok;

  // Score the latched round: off-wheel results count as the house number 0.
  always_comb begin
    eff_rand = (rand_q > MAX_V) ? '0 : rand_q;
    case (mode_q)
      M_EXACT: round_win = (guess_q == eff_rand);
      M_EVEN:  round_win = (eff_rand != '0) && !eff_rand[0];
      M_ODD:   round_win = (eff_rand != '0) && eff_rand[0];
      default: round_win = (eff_rand != '0) && (eff_rand > HALF_V);
    endcase
    bal_x  = EXT_W'(balance_q);
    bet_x  = EXT_W'(bet_q);
    gain_x = (mode_q == M_EXACT) ? (bet_x * PAY_X) : bet_x;
    sum_x  = bal_x + gain_x;
    if (round_win) begin
      new_bal_x = (sum_x > BAL_MAX_X) ? BAL_MAX_X : sum_x;
    end else begin
      new_bal_x = (bet_x > bal_x) ? '0 : (bal_x - bet_x);
    end
    spin_ok = (bet != '0) && (EXT_W'(bet) <= bal_x) &&
              ((mode != M_EXACT) || (guess <= MAX_V));
  end

  // Next-state logic: start_game outranks everything, pulses default low.
  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    rounds_d  = rounds_q;
    win_d     = 1'b0;
    lose_d    = 1'b0;
    err_d     = 1'b0;
    mode_d    = mode_q;
    guess_d   = guess_q;
    bet_d     = bet_q;
    rand_d    = rand_q;
    if (start_game) begin
      state_d   = S_PLAY;
      balance_d = START_V;
      rounds_d  = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (spin) begin
            if (spin_ok) begin
              mode_d  = mode;
              guess_d = guess;
              bet_d   = bet;
              rand_d  = randnum;
              state_d = S_EVAL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_EVAL: begin
          balance_d = BAL_W'(new_bal_x);
          win_d     = round_win;
          lose_d    = !round_win;
          if (rounds_q != 8'hFF) begin
            rounds_d = rounds_q + 8'd1;
          end
          if (new_bal_x >= WIN_X) begin
            state_d = S_WON;
          end else if (new_bal_x == '0) begin
            state_d = S_LOST;
          end else begin
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset drops straight to IDLE with a fresh balance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      balance_q <= START_V;
      rounds_q  <= '0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      err_q     <= 1'b0;
      mode_q    <= '0;
      guess_q   <= '0;
      bet_q     <= '0;
      rand_q    <= '0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      rounds_q  <= rounds_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      err_q     <= err_d;
      mode_q    <= mode_d;
      guess_q   <= guess_d;
      bet_q     <= bet_d;
      rand_q    <= rand_d;
    end
  end

  assign balance    = balance_q;
  assign state_out  = state_q;
  assign win_pulse  = win_q;
  assign lose_pulse = lose_q;
  assign bet_err    = err_q;
  assign rounds     = rounds_q;

endmodule

// File: tb/tb_roulette_param.sv
// Scoreboard bench for roulette_param. A behavioural game model predicts every
// cycle's outputs. Those predictions are queued as stimulus is driven, and are
// popped and compared once the clock edge has produced the DUT's outputs.
module tb_roulette_param;

  // Six-bit wheel numbers let off-wheel results (> MAX_NUM) reach the DUT.
  localparam int NUM_W     = 6;
  localparam int MAX_NUM   = 31;
  localparam int BAL_W     = 6;
  localparam int BET_W     = 3;
  localparam int START_BAL = 10;
  localparam int WIN_BAL   = 20;
  localparam int EXACT_PAY = 8;
  localparam int BAL_MAX   = (1 << BAL_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_game;
  logic             spin;
  logic [1:0]       mode;
  logic [NUM_W-1:0] guess;
  logic [BET_W-1:0] bet;
  logic [NUM_W-1:0] randnum;
  logic [BAL_W-1:0] balance;
  logic [2:0]       state_out;
  logic             win_pulse;
  logic             lose_pulse;
  logic             bet_err;
  logic [7:0]       rounds;

  roulette_param #(
    .NUM_W(NUM_W), .MAX_NUM(MAX_NUM), .BAL_W(BAL_W), .BET_W(BET_W),
    .START_BAL(START_BAL), .WIN_BAL(WIN_BAL), .EXACT_PAY(EXACT_PAY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_game(start_game), .spin(spin),
    .mode(mode), .guess(guess), .bet(bet), .randnum(randnum),
    .balance(balance), .state_out(state_out), .win_pulse(win_pulse),
    .lose_pulse(lose_pulse), .bet_err(bet_err), .rounds(rounds)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    bal;
    int    st;
    int    rnd;
    int    w;
    int    l;
    int    e;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference game model
  int m_state, m_bal, m_rnd, m_w, m_l, m_e;
  int m_mode, m_guess, m_bet, m_rand;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    tests_run++;
    if (obs != expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic pushExpected(input string tag);
    exp_t e;
    e.tag = tag; e.bal = m_bal; e.st = m_state; e.rnd = m_rnd;
    e.w = m_w; e.l = m_l; e.e = m_e;
    exp_q.push_back(e);
  endtask

  task automatic compareNext();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_bal"},   int'(balance),    e.bal);
      checkOutput({e.tag, "_state"}, int'(state_out),  e.st);
      checkOutput({e.tag, "_rounds"},int'(rounds),     e.rnd);
      checkOutput({e.tag, "_win"},   int'(win_pulse),  e.w);
      checkOutput({e.tag, "_lose"},  int'(lose_pulse), e.l);
      checkOutput({e.tag, "_err"},   int'(bet_err),    e.e);
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic modelStep(input bit st, input bit sp, input int md,
                           input int g, input int b, input int r);
    int  eff;
    bit  won;
    m_w = 0; m_l = 0; m_e = 0;
    if (st) begin
      m_state = 1; m_bal = START_BAL; m_rnd = 0;
    end else if (m_state == 1) begin
      if (sp) begin
        if (b >= 1 && b <= m_bal && (md != 0 || g <= MAX_NUM)) begin
          m_mode = md; m_guess = g; m_bet = b; m_rand = r; m_state = 2;
        end else begin
          m_e = 1;
        end
      end
    end else if (m_state == 2) begin
      eff = (m_rand > MAX_NUM) ? 0 : m_rand;
      case (m_mode)
        0: won = (m_guess == eff);
        1: won = (eff != 0) && (eff % 2 == 0);
        2: won = (eff % 2 == 1);
        default: won = (eff > MAX_NUM / 2);
      endcase
      if (won) begin
        m_bal = m_bal + ((m_mode == 0) ? m_bet * EXACT_PAY : m_bet);
        if (m_bal > BAL_MAX) m_bal = BAL_MAX;
        m_w = 1;
      end else begin
        m_bal = m_bal - m_bet;
        m_l = 1;
      end
      if (m_rnd < 255) m_rnd++;
      if (m_bal >= WIN_BAL) m_state = 3;
      else if (m_bal == 0) m_state = 4;
      else m_state = 1;
    end
  endtask

  // Drive one cycle of stimulus from a falling edge, then score it on the next one.
  task automatic applyStimulus(input string tag, input bit st, input bit sp,
                               input int md, input int g, input int b, input int r);
    start_game = st;
    spin       = sp;
    mode       = 2'(md);
    guess      = NUM_W'(g);
    bet        = BET_W'(b);
    randnum    = NUM_W'(r);
    modelStep(st, sp, md, g, b, r);
    pushExpected(tag);
    @(negedge clk);
    compareNext();
    start_game = 1'b0;
    spin       = 1'b0;
  endtask

  task automatic tick(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  // One complete round: spin cycle, then the evaluation cycle.
  task automatic playRound(input string tag, input int md, input int g,
                           input int b, input int r);
    applyStimulus({tag, "_spin"}, 1'b0, 1'b1, md, g, b, r);
    tick({tag, "_eval"});
  endtask

  // Assert reset asynchronously and check its effect before any clock edge.
  task automatic applyReset(input string tag);
    reset_n = 1'b0;
    m_state = 0; m_bal = START_BAL; m_rnd = 0; m_w = 0; m_l = 0; m_e = 0;
    pushExpected(tag);
    #1;
    compareNext();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; start_game = 1'b0; spin = 1'b0;
    mode = '0; guess = '0; bet = '0; randnum = '0;
    m_mode = 0; m_guess = 0; m_bet = 0; m_rand = 0;
    @(negedge clk);
    applyReset("reset");
    applyStimulus("idle_spin_ignored", 1'b0, 1'b1, 1, 0, 1, 2);
    tick("idle_hold");

    // Exact hit on 7, then an even win reaching WON; spins are then ignored.
    applyStimulus("start1", 1'b1, 1'b0, 0, 0, 0, 0);
    playRound("exact7", 0, 7, 1, 7);
    tick("after_win");
    playRound("even_to_won", 1, 0, 2, 4);
    applyStimulus("won_spin_ignored", 1'b0, 1'b1, 1, 0, 1, 4);
    tick("won_hold");

    // Odd bet on the house number loses, then two rejected stakes.
    applyStimulus("start2", 1'b1, 1'b0, 0, 0, 0, 0);
    playRound("odd_zero", 2, 0, 4, 0);
    applyStimulus("bet_zero", 1'b0, 1'b1, 1, 0, 0, 2);
    tick("bet_zero_after");
    applyStimulus("bet_over", 1'b0, 1'b1, 1, 0, 7, 2);
    tick("bet_over_after");
    applyStimulus("guess_off_wheel", 1'b0, 1'b1, 0, 40, 1, 3);
    tick("guess_off_after");

    // Climb to 19, then an exact win that clamps at the balance ceiling.
    applyStimulus("start3", 1'b1, 1'b0, 0, 0, 0, 0);
    playRound("even_a", 1, 0, 4, 2);
    playRound("even_b", 1, 0, 5, 6);
    playRound("exact_sat", 0, 3, 7, 3);

    // Off-wheel results count as 0: exact 0 wins, even loses.
    applyStimulus("start4", 1'b1, 1'b0, 0, 0, 0, 0);
    playRound("offwheel_exact0", 0, 0, 1, 40);
    playRound("offwheel_even", 1, 0, 2, 40);

    // Drain to 1 and lose on high with 15, then restart from LOST.
    applyStimulus("start5", 1'b1, 1'b0, 0, 0, 0, 0);
    playRound("high16", 3, 0, 1, 16);
    playRound("odd_loss_a", 2, 0, 7, 2);
    playRound("odd_loss_b", 2, 0, 3, 2);
    playRound("high15_lost", 3, 0, 1, 15);
    applyStimulus("restart_lost", 1'b1, 1'b0, 0, 0, 0, 0);

    // Reset during EVAL, then start and spin together.
    applyStimulus("pre_reset_spin", 1'b0, 1'b1, 1, 0, 2, 4);
    applyReset("reset_mid_eval");
    tick("post_reset_idle");
    applyStimulus("start_and_spin", 1'b1, 1'b1, 1, 0, 2, 4);
    tick("no_eval_after");

    // start_game during EVAL discards the in-flight round.
    applyStimulus("spin_then_start", 1'b0, 1'b1, 1, 0, 3, 4);
    applyStimulus("start_in_eval", 1'b1, 1'b0, 0, 0, 0, 0);
    tick("after_discard");

    // Alternate win/loss long enough to saturate the round counter.
    for (int i = 0; i < 130; i++) begin
      playRound("sat_win", 1, 0, 1, 2);
      playRound("sat_loss", 2, 0, 1, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
